// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master shared data-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  localparam logic Port0 = 1'b0;
  localparam logic Port1 = 1'b1;

  function automatic state_e own_state(input logic port);
    return port ? StOwn1 : StOwn0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both master ports plus the shared memory port; slave side faces the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              I_m0_req;
  logic              I_m0_we;
  logic [ADDR_W-1:0] I_m0_addr;
  logic [31:0]       I_m0_wdata;
  logic [3:0]        I_m0_be;
  logic              O_m0_gnt;
  logic              O_m0_rvalid;
  logic [31:0]       O_m0_rdata;

  logic              I_m1_req;
  logic              I_m1_we;
  logic [ADDR_W-1:0] I_m1_addr;
  logic [31:0]       I_m1_wdata;
  logic [3:0]        I_m1_be;
  logic              O_m1_gnt;
  logic              O_m1_rvalid;
  logic [31:0]       O_m1_rdata;

  logic              O_mem_en;
  logic              O_mem_we;
  logic [ADDR_W-1:0] O_mem_addr;
  logic [31:0]       O_mem_wdata;
  logic [3:0]        O_mem_be;
  logic [31:0]       I_mem_rdata;

  modport slave (
    input  I_m0_req, I_m0_we, I_m0_addr, I_m0_wdata, I_m0_be,
    output O_m0_gnt, O_m0_rvalid, O_m0_rdata,
    input  I_m1_req, I_m1_we, I_m1_addr, I_m1_wdata, I_m1_be,
    output O_m1_gnt, O_m1_rvalid, O_m1_rdata,
    output O_mem_en, O_mem_we, O_mem_addr, O_mem_wdata, O_mem_be,
    input  I_mem_rdata
  );

  modport master (
    output I_m0_req, I_m0_we, I_m0_addr, I_m0_wdata, I_m0_be,
    input  O_m0_gnt, O_m0_rvalid, O_m0_rdata,
    output I_m1_req, I_m1_we, I_m1_addr, I_m1_wdata, I_m1_be,
    input  O_m1_gnt, O_m1_rvalid, O_m1_rdata,
    input  O_mem_en, O_mem_we, O_mem_addr, O_mem_wdata, O_mem_be,
    output I_mem_rdata
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone requester wins; on contention the port that did not win last.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a loader/debug port onto one data memory with bounded bursts.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input logic          I_clk,
  input logic          I_rst,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rvalid0_q, rvalid1_q;
  logic [1:0] req, rr_gnt, gnt;
  logic       own, oth, win;

  assign req = {bus.I_m1_req, bus.I_m0_req};
  assign own = (state_q == StOwn1) ? Port1 : Port0;
  assign oth = ~own;
  assign win = gnt[Port1];

  arb_rr2 u_arb_rr2 (
    .req  (req),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state_q   <= StIdle;
      last_q    <= Port1;
      cnt_q     <= 4'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= gnt[Port0] & ~bus.I_m0_we;
      rvalid1_q <= gnt[Port1] & ~bus.I_m1_we;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (gnt == 2'b00) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
    end else if (state_q == own_state(win)) begin
      cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    end else begin
      state_d = own_state(win);
      cnt_d   = 4'd1;
      last_d  = win;
    end
  end

  always_comb begin
    gnt = 2'b00;
    unique case (state_q)
      StOwn0, StOwn1: begin
        // Owner keeps the bus unless the other side is waiting and the burst is spent.
        if (req[own] && (!req[oth] || cnt_q < MaxBurst)) begin
          gnt[own] = 1'b1;
        end else if (req[oth]) begin
          gnt[oth] = 1'b1;
        end
      end
      default: gnt = rr_gnt;
    endcase
    if (!I_rst) gnt = 2'b00;

    bus.O_mem_en    = 1'b0;
    bus.O_mem_we    = 1'b0;
    bus.O_mem_addr  = {ADDR_W{1'b0}};
    bus.O_mem_wdata = 32'd0;
    bus.O_mem_be    = 4'd0;
    if (gnt[Port0]) begin
      bus.O_mem_en    = 1'b1;
      bus.O_mem_we    = bus.I_m0_we;
      bus.O_mem_addr  = bus.I_m0_addr;
      bus.O_mem_wdata = bus.I_m0_wdata;
      bus.O_mem_be    = bus.I_m0_be;
    end else if (gnt[Port1]) begin
      bus.O_mem_en    = 1'b1;
      bus.O_mem_we    = bus.I_m1_we;
      bus.O_mem_addr  = bus.I_m1_addr;
      bus.O_mem_wdata = bus.I_m1_wdata;
      bus.O_mem_be    = bus.I_m1_be;
    end
  end

  assign bus.O_m0_gnt    = gnt[Port0];
  assign bus.O_m1_gnt    = gnt[Port1];
  assign bus.O_m0_rvalid = rvalid0_q;
  assign bus.O_m1_rvalid = rvalid1_q;
  assign bus.O_m0_rdata  = rvalid0_q ? bus.I_mem_rdata : 32'd0;
  assign bus.O_m1_rdata  = rvalid1_q ? bus.I_mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MAX_BURST=4, one with MAX_BURST=1.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   exp_owner;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) a ();
  mem_arbiter_if #(.ADDR_W(32)) b ();

  mem_arbiter #(.ADDR_W(32), .MAX_BURST(4)) u_dut4 (
    .I_clk (clk),
    .I_rst (rst_n),
    .bus   (a.slave)
  );

  mem_arbiter #(.ADDR_W(32), .MAX_BURST(1)) u_dut1 (
    .I_clk (clk),
    .I_rst (rst_n),
    .bus   (b.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_all();
    a.I_m0_req = 1'b0; a.I_m0_we = 1'b0; a.I_m0_addr = '0; a.I_m0_wdata = '0; a.I_m0_be = '0;
    a.I_m1_req = 1'b0; a.I_m1_we = 1'b0; a.I_m1_addr = '0; a.I_m1_wdata = '0; a.I_m1_be = '0;
    b.I_m0_req = 1'b0; b.I_m0_we = 1'b0; b.I_m0_addr = '0; b.I_m0_wdata = '0; b.I_m0_be = '0;
    b.I_m1_req = 1'b0; b.I_m1_we = 1'b0; b.I_m1_addr = '0; b.I_m1_wdata = '0; b.I_m1_be = '0;
  endtask

  initial begin
    clear_all();
    a.I_mem_rdata = 32'hDEADBEEF;
    b.I_mem_rdata = 32'hDEADBEEF;
    rst_n = 1'b0;
    a.I_m0_req = 1'b1;
    a.I_m1_req = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt0", a.O_m0_gnt, 0);
    chk("rst_gnt1", a.O_m1_gnt, 0);
    chk("rst_mem_en", a.O_mem_en, 0);
    chk("rst_rvalid0", a.O_m0_rvalid, 0);
    chk("rst_b_mem_en", b.O_mem_en, 0);
    a.I_m0_req = 1'b0;
    a.I_m1_req = 1'b0;
    rst_n = 1'b1;

    // m0 read at 0x10
    @(posedge clk); #1;
    a.I_m0_req = 1'b1; a.I_m0_we = 1'b0; a.I_m0_addr = 32'h10;
    #1;
    chk("rd_gnt0", a.O_m0_gnt, 1);
    chk("rd_mem_en", a.O_mem_en, 1);
    chk("rd_mem_we", a.O_mem_we, 0);
    chk("rd_mem_addr", a.O_mem_addr, 32'h10);
    @(posedge clk); #1;
    a.I_m0_req = 1'b0;
    #1;
    chk("rd_rvalid0", a.O_m0_rvalid, 1);
    chk("rd_rdata0", a.O_m0_rdata, 32'hDEADBEEF);
    chk("rd_idle_en", a.O_mem_en, 0);
    chk("rd_idle_addr", a.O_mem_addr, 0);
    chk("rd_rvalid1", a.O_m1_rvalid, 0);
    chk("rd_rdata1", a.O_m1_rdata, 0);
    @(posedge clk); #2;
    chk("rd_rvalid0_off", a.O_m0_rvalid, 0);
    chk("rd_rdata0_off", a.O_m0_rdata, 0);

    // m1 write 0x20 = 0x12345678, be 0011
    @(posedge clk); #1;
    a.I_m1_req = 1'b1; a.I_m1_we = 1'b1; a.I_m1_addr = 32'h20;
    a.I_m1_wdata = 32'h12345678; a.I_m1_be = 4'b0011;
    #1;
    chk("wr_gnt1", a.O_m1_gnt, 1);
    chk("wr_gnt0", a.O_m0_gnt, 0);
    chk("wr_mem_we", a.O_mem_we, 1);
    chk("wr_mem_be", a.O_mem_be, 4'b0011);
    chk("wr_mem_wdata", a.O_mem_wdata, 32'h12345678);
    chk("wr_mem_addr", a.O_mem_addr, 32'h20);
    @(posedge clk); #1;
    a.I_m1_req = 1'b0;
    #1;
    chk("wr_no_rvalid", a.O_m1_rvalid, 0);
    chk("wr_idle_be", a.O_mem_be, 0);
    chk("wr_idle_wdata", a.O_mem_wdata, 0);

    // Continuous contention, MAX_BURST=4: m0 x4, m1 x4, m0 x4
    @(posedge clk); #1;
    a.I_m0_req = 1'b1; a.I_m0_we = 1'b0; a.I_m0_addr = 32'h100;
    a.I_m1_req = 1'b1; a.I_m1_we = 1'b0; a.I_m1_addr = 32'h200;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      #1;
      exp_owner = (i / 4) % 2;
      chk($sformatf("burst_gnt0_%0d", i), a.O_m0_gnt, (exp_owner == 0));
      chk($sformatf("burst_gnt1_%0d", i), a.O_m1_gnt, (exp_owner == 1));
      chk($sformatf("burst_addr_%0d", i), a.O_mem_addr, (exp_owner == 1) ? 32'h200 : 32'h100);
      chk($sformatf("burst_rvalid0_%0d", i), a.O_m0_rvalid, (i > 0) && (((i - 1) / 4) % 2 == 0));
    end

    // m0 alone keeps the bus well past MAX_BURST, then yields at once to m1
    @(posedge clk); #1;
    a.I_m0_req = 1'b0; a.I_m1_req = 1'b0;
    @(posedge clk); #1;
    a.I_m0_req = 1'b1; a.I_m0_we = 1'b1; a.I_m0_addr = 32'h44;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      #1;
      chk($sformatf("solo_gnt0_%0d", i), a.O_m0_gnt, 1);
    end
    @(posedge clk); #1;
    a.I_m1_req = 1'b1; a.I_m1_we = 1'b1;
    #1;
    chk("solo_yield_gnt1", a.O_m1_gnt, 1);
    chk("solo_yield_gnt0", a.O_m0_gnt, 0);

    // Reset pulsed right after an accepted m1 read
    @(posedge clk); #1;
    a.I_m0_req = 1'b0; a.I_m1_req = 1'b0;
    @(posedge clk); #1;
    a.I_m1_req = 1'b1; a.I_m1_we = 1'b0; a.I_m1_addr = 32'h30;
    #1;
    chk("rst_mid_gnt1", a.O_m1_gnt, 1);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    a.I_m1_req = 1'b0;
    #1;
    chk("rst_mid_rvalid1", a.O_m1_rvalid, 0);
    chk("rst_mid_rdata1", a.O_m1_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a.I_m0_req = 1'b1; a.I_m0_we = 1'b1;
    a.I_m1_req = 1'b1; a.I_m1_we = 1'b1;
    #1;
    chk("rst_mid_rvalid1_after", a.O_m1_rvalid, 0);
    chk("rst_mid_first_gnt0", a.O_m0_gnt, 1);
    chk("rst_mid_first_gnt1", a.O_m1_gnt, 0);
    @(posedge clk); #1;
    a.I_m0_req = 1'b0; a.I_m1_req = 1'b0;

    // MAX_BURST=1: strict alternation
    @(posedge clk); #1;
    b.I_m0_req = 1'b1; b.I_m0_we = 1'b1; b.I_m0_addr = 32'h50;
    b.I_m1_req = 1'b1; b.I_m1_we = 1'b1; b.I_m1_addr = 32'h60;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      #1;
      chk($sformatf("alt_gnt0_%0d", i), b.O_m0_gnt, (i % 2 == 0));
      chk($sformatf("alt_gnt1_%0d", i), b.O_m1_gnt, (i % 2 == 1));
    end
    @(posedge clk); #1;
    clear_all();
    @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
